// File: rtl/lane_assist_ctrl_pkg.sv
// Shared definitions for the lane-assist sequencer: FSM state encodings
// and the default tuning constants.
package lane_assist_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_CENTER   = 3'd1,
        ST_CORR_R   = 3'd2,
        ST_CORR_L   = 3'd3,
        ST_OVERRIDE = 3'd4,
        ST_WARN     = 3'd5
    } state_e;

    localparam int DEBOUNCE_DEF    = 3;
    localparam int HOLDOFF_DEF     = 8;
    localparam int MAX_CORRECT_DEF = 16;
    localparam int CNT_W_DEF       = 5;

endpackage

// File: rtl/lane_assist_ctrl_if.sv
// Signal bundle between the driver-side controls / sensors and the
// lane-assist sequencer. The slave side is the sequencer itself.
interface lane_assist_ctrl_if;

    logic       enable;
    logic       near_right;
    logic       near_left;
    logic       turn_signal;
    logic       assist_right;
    logic       assist_left;
    logic       assist_disable;
    logic       warn;
    logic [2:0] state;

    modport master (
        output enable, near_right, near_left, turn_signal,
        input  assist_right, assist_left, assist_disable, warn, state
    );

    modport slave (
        input  enable, near_right, near_left, turn_signal,
        output assist_right, assist_left, assist_disable, warn, state
    );

endinterface

// File: rtl/lane_assist_ctrl_sensor_debounce.sv
// Debounce filter for one raw lane-edge proximity sensor: the filtered bit
// only follows the raw input after DEBOUNCE consecutive disagreeing samples.
module sensor_debounce #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic filt
);

    logic [CNT_W-1:0] cnt;

    // Count disagreeing samples; flip the filtered bit on the last one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (raw != filt) begin
            if (cnt == CNT_W'(DEBOUNCE - 1)) begin
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/lane_assist_ctrl.sv
// Lane-assist sequencer: debounces both edge sensors, arbitrates left/right
// correction, suspends assist during driver lane changes and escalates
// prolonged correction to a driver warning. Outputs are Moore-decoded.
module lane_assist_ctrl
    import lane_assist_pkg::*;
#(
    parameter int DEBOUNCE    = DEBOUNCE_DEF,
    parameter int HOLDOFF     = HOLDOFF_DEF,
    parameter int MAX_CORRECT = MAX_CORRECT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    lane_assist_ctrl_if.slave bus
);

    logic             filt_r;
    logic             filt_l;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] corr_q;
    logic [CNT_W-1:0] corr_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    sensor_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_deb_r (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (bus.near_right),
        .filt (filt_r)
    );

    sensor_debounce #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) u_deb_l (
        .CLK  (CLK),
        .RST  (RST),
        .raw  (bus.near_left),
        .filt (filt_l)
    );

    // Next-state and counter update; enable and turn signal override the per-state rules.
    always_comb begin
        state_d = state_q;
        corr_d  = corr_q;
        hold_d  = hold_q;

        if (!bus.enable) begin
            state_d = ST_OFF;
        end else if (bus.turn_signal &&
                     (state_q inside {ST_CENTER, ST_CORR_R, ST_CORR_L, ST_WARN})) begin
            state_d = ST_OVERRIDE;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_CENTER;
                ST_CENTER: begin
                    if (filt_r && !filt_l)
                        state_d = ST_CORR_R;
                    else if (filt_l && !filt_r)
                        state_d = ST_CORR_L;
                end
                ST_CORR_R: begin
                    if (!filt_r)
                        state_d = ST_CENTER;
                    else if (corr_q == CNT_W'(MAX_CORRECT - 1))
                        state_d = ST_WARN;
                end
                ST_CORR_L: begin
                    if (!filt_l)
                        state_d = ST_CENTER;
                    else if (corr_q == CNT_W'(MAX_CORRECT - 1))
                        state_d = ST_WARN;
                end
                ST_WARN: begin
                    if (!filt_r && !filt_l)
                        state_d = ST_CENTER;
                end
                ST_OVERRIDE: begin
                    if (!bus.turn_signal && (hold_q == CNT_W'(HOLDOFF - 1)))
                        state_d = ST_CENTER;
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Correction time restarts whenever a correction state is freshly entered.
        if (state_d == ST_CORR_R || state_d == ST_CORR_L)
            corr_d = (state_d != state_q) ? '0 : sat_inc(corr_q);

        // Hold-off only runs while the indicator is released.
        if (state_d == ST_OVERRIDE)
            hold_d = (state_q != ST_OVERRIDE || bus.turn_signal) ? '0 : sat_inc(hold_q);
    end

    // State and counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_OFF;
            corr_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            corr_q  <= corr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.assist_right   = (state_q == ST_CORR_R);
    assign bus.assist_left    = (state_q == ST_CORR_L);
    assign bus.assist_disable = (state_q == ST_OFF) || (state_q == ST_OVERRIDE) ||
                                (state_q == ST_WARN);
    assign bus.warn           = (state_q == ST_WARN);
    assign bus.state          = state_q;

endmodule

// File: tb/tb_lane_assist_ctrl.sv
// Self-checking bench for lane_assist_ctrl with default parameters.
// Every cycle's inputs are driven on the falling edge together with the
// expected state after the next rising edge; the expectation is queued and
// checked one time unit after that edge.
module tb_lane_assist_ctrl;

    localparam logic [2:0] S_OFF = 3'd0;
    localparam logic [2:0] S_CEN = 3'd1;
    localparam logic [2:0] S_CR  = 3'd2;
    localparam logic [2:0] S_CL  = 3'd3;
    localparam logic [2:0] S_OV  = 3'd4;
    localparam logic [2:0] S_WRN = 3'd5;

    typedef struct {
        logic       rst;
        logic       en;
        logic       nr;
        logic       nl;
        logic       ts;
        logic [2:0] exp_state;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        string      tag;
        int         idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   step_no = 0;

    vec_t vecs[$];
    exp_t sb[$];

    lane_assist_ctrl_if bus();

    lane_assist_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic void add(input logic r, input logic e, input logic nr,
                                input logic nl, input logic ts, input logic [2:0] s);
        vec_t v;
        v.rst = r; v.en = e; v.nr = nr; v.nl = nl; v.ts = ts; v.exp_state = s;
        vecs.push_back(v);
    endfunction

    // Output decode expected for a given state: {assist_right, assist_left, assist_disable, warn}
    function automatic logic [3:0] exp_outs(input logic [2:0] s);
        case (s)
            S_OFF:   return 4'b0010;
            S_CEN:   return 4'b0000;
            S_CR:    return 4'b1000;
            S_CL:    return 4'b0100;
            S_OV:    return 4'b0010;
            S_WRN:   return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic check_one();
        exp_t       e;
        logic [3:0] act;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: queue empty at step %0d, got 0 entries, required 1", step_no);
            return;
        end
        e   = sb.pop_front();
        act = {bus.assist_right, bus.assist_left, bus.assist_disable, bus.warn};
        checks++;
        if (bus.state === e.st) passes++;
        else $display("FAIL %s[%0d] state: got %0d required %0d", e.tag, e.idx, bus.state, e.st);
        checks++;
        if (act === exp_outs(e.st)) passes++;
        else $display("FAIL %s[%0d] outputs r/l/dis/warn: got %b required %b",
                      e.tag, e.idx, act, exp_outs(e.st));
        checks++;
        if (!(bus.assist_right && bus.assist_left)) passes++;
        else $display("FAIL %s[%0d] exclusion: got both assist high, required at most one",
                      e.tag, e.idx);
    endtask

    task automatic step(input string tag, input int idx, input logic r, input logic e,
                        input logic nr, input logic nl, input logic ts, input logic [2:0] s);
        exp_t x;
        @(negedge clk);
        rst             = r;
        bus.enable      = e;
        bus.near_right  = nr;
        bus.near_left   = nl;
        bus.turn_signal = ts;
        x.st = s; x.tag = tag; x.idx = idx;
        sb.push_back(x);
        @(posedge clk);
        #1;
        step_no++;
        check_one();
    endtask

    initial begin
        bus.enable      = 1'b1;
        bus.near_right  = 1'b0;
        bus.near_left   = 1'b0;
        bus.turn_signal = 1'b0;

        // reset held two cycles with enable high, then CENTER one edge after release
        add(1, 1, 0, 0, 0, S_OFF);
        add(1, 1, 0, 0, 0, S_OFF);
        add(0, 1, 0, 0, 0, S_CEN);
        // two-cycle glitch on near_right: no effect
        add(0, 1, 1, 0, 0, S_CEN);
        add(0, 1, 1, 0, 0, S_CEN);
        add(0, 1, 0, 0, 0, S_CEN);
        add(0, 1, 0, 0, 0, S_CEN);
        // three-cycle hold: CORR_R on the 4th edge, CENTER 4 edges after drop
        add(0, 1, 1, 0, 0, S_CEN);
        add(0, 1, 1, 0, 0, S_CEN);
        add(0, 1, 1, 0, 0, S_CEN);
        add(0, 1, 0, 0, 0, S_CR);
        add(0, 1, 0, 0, 0, S_CR);
        add(0, 1, 0, 0, 0, S_CR);
        add(0, 1, 0, 0, 0, S_CEN);
        // both sensors for six cycles: conflict keeps CENTER
        for (int i = 0; i < 6; i++) add(0, 1, 1, 1, 0, S_CEN);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, S_CEN);

        for (int i = 0; i < vecs.size(); i++)
            step("table", i, vecs[i].rst, vecs[i].en, vecs[i].nr, vecs[i].nl,
                 vecs[i].ts, vecs[i].exp_state);

        // escalation: 16 cycles of CORR_L, then WARN; CENTER 4 edges after clearing
        for (int i = 0; i < 3; i++)  step("esc_deb", i, 0, 1, 0, 1, 0, S_CEN);
        for (int i = 0; i < 16; i++) step("esc_corr", i, 0, 1, 0, 1, 0, S_CL);
        for (int i = 0; i < 3; i++)  step("esc_warn", i, 0, 1, 0, 1, 0, S_WRN);
        for (int i = 0; i < 3; i++)  step("esc_clr", i, 0, 1, 0, 0, 0, S_WRN);
        step("esc_clr", 3, 0, 1, 0, 0, 0, S_CEN);

        // override from CORR_R with a restart of the hold-off at count 5
        for (int i = 0; i < 3; i++) step("ovr_deb", i, 0, 1, 1, 0, 0, S_CEN);
        step("ovr_corr", 0, 0, 1, 1, 0, 0, S_CR);
        step("ovr_enter", 0, 0, 1, 1, 0, 1, S_OV);
        step("ovr_enter", 1, 0, 1, 0, 0, 1, S_OV);
        for (int i = 0; i < 5; i++) step("ovr_rel1", i, 0, 1, 0, 0, 0, S_OV);
        step("ovr_reassert", 0, 0, 1, 0, 0, 1, S_OV);
        for (int i = 0; i < 7; i++) step("ovr_rel2", i, 0, 1, 0, 0, 0, S_OV);
        step("ovr_rel2", 7, 0, 1, 0, 0, 0, S_CEN);
        step("ovr_after", 0, 0, 1, 0, 0, 0, S_CEN);

        // enable drop during CORR_L, then reset during OVERRIDE
        for (int i = 0; i < 3; i++) step("dis_deb", i, 0, 1, 0, 1, 0, S_CEN);
        step("dis_corr", 0, 0, 1, 0, 1, 0, S_CL);
        step("dis_corr", 1, 0, 1, 0, 1, 0, S_CL);
        step("dis_off", 0, 0, 0, 0, 1, 0, S_OFF);
        step("dis_off", 1, 0, 0, 0, 1, 0, S_OFF);
        step("dis_on", 0, 0, 1, 0, 1, 0, S_CEN);
        step("dis_on", 1, 0, 1, 0, 1, 0, S_CL);
        step("rst_ovr", 0, 0, 1, 0, 1, 1, S_OV);
        step("rst_mid", 0, 1, 1, 0, 1, 1, S_OFF);
        // debounce state must also be cleared: no CORR_L after release
        for (int i = 0; i < 4; i++) step("rst_after", i, 0, 1, 0, 0, 0, S_CEN);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lane_assist_ctrl.md
# lane_assist_ctrl

Sequencer that sits in front of the `lane_assist` datapath and drives its `assist_right`, `assist_left` and `assist_disable` inputs. It debounces the raw lane-edge proximity sensors and enforces mutual exclusion between left and right correction. It suspends assist while the driver signals a lane change, then restores it after a hold-off. Continuous correction beyond a time limit escalates to a driver warning.

## Interface
- `DEBOUNCE`, default 3: consecutive samples a raw sensor must differ from its filtered value before the filtered value flips (≥1).
- `HOLDOFF`, default 8: cycles after `turn_signal` release before assist resumes (≥1).
- `MAX_CORRECT`, default 16: cycles of continuous correction before escalating to WARN (≥2).
- `CNT_W`, default 5: counter width; must hold max(`DEBOUNCE`, `HOLDOFF`, `MAX_CORRECT`).
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset; one clock, reset is synchronous and active-high.
- `enable`  in  1  driver master switch for lane assist.
- `near_right`  in  1  raw sensor: car too close to right lane edge.
- `near_left`  in  1  raw sensor: car too close to left lane edge.
- `turn_signal`  in  1  either turn indicator active (intentional lane change).
- `assist_right`  out  1  to `lane_assist`: steer away from right edge.
- `assist_left`  out  1  to `lane_assist`: steer away from left edge.
- `assist_disable`  out  1  to `lane_assist`: assist feature off.
- `warn`  out  1  driver warning (prolonged correction).
- `state`  out  3  current FSM state encoding, for diagnostics.

## Operation
- Debounce: each sensor has a filtered bit `filt_r` or `filt_l` and a counter.
  - Counter increments when raw ≠ filtered. It clears when raw = filtered.
  - On reaching `DEBOUNCE`, the filtered bit toggles and the counter clears.
- FSM states: OFF=0, CENTER=1, CORR_R=2, CORR_L=3, OVERRIDE=4, WARN=5. Encodings 6 and 7 are illegal and go to OFF.
- Transition priority:
  - `RST`: OFF.
  - `!enable`: OFF from any state.
  - `turn_signal`: OVERRIDE from CENTER, CORR_R, CORR_L or WARN.
  - Otherwise, the per-state rules below apply.
- OFF: on `enable`=1, go to CENTER.
- CENTER:
  - `filt_r`=1 and `filt_l`=0: go to CORR_R.
  - `filt_l`=1 and `filt_r`=0: go to CORR_L.
  - Both set (conflict): stay in CENTER.
- CORR_R:
  - `filt_r`=0: go to CENTER.
  - `corr_cnt` reaches `MAX_CORRECT`-1: go to WARN.
  - `filt_l` is ignored. A switch to CORR_L only happens via CENTER.
- CORR_L: mirror of CORR_R.
- WARN: once `filt_r`=0 and `filt_l`=0, go to CENTER.
- OVERRIDE:
  - While `turn_signal`=1, `hold_cnt` is held at 0.
  - After release, `hold_cnt` increments each cycle. At `HOLDOFF`-1 the FSM goes to CENTER.
  - Re-assertion of `turn_signal` during the count restarts it.
- `corr_cnt` clears on entry to CORR_R or CORR_L and increments each cycle spent in those states. `hold_cnt` clears on OVERRIDE entry. Both counters saturate and never wrap.
- Output decode (Moore, from the state register only):
  - `assist_right` = CORR_R.
  - `assist_left` = CORR_L.
  - `assist_disable` = OFF, OVERRIDE or WARN.
  - `warn` = WARN.
- `assist_right` and `assist_left` are never 1 simultaneously.

## Timing
- Reset values: state=OFF, so `assist_disable`=1 and all other outputs 0. Filtered bits and all counters are 0.
- Sensor latency with `DEBOUNCE`=3: if `near_right` is high at edges 1, 2 and 3, `filt_r` sets at edge 3. The FSM enters CORR_R at edge 4, and `assist_right` is high after edge 4.
- Release latency is symmetric: `DEBOUNCE`+1 edges.
- A raw glitch shorter than `DEBOUNCE` samples produces no output change.
- Escalation: WARN is entered exactly `MAX_CORRECT` edges after CORR entry.
- `enable` falling: OFF at the next edge, regardless of counters.
- `RST` mid-operation: everything returns to reset values at that edge, including debounce state.
- `turn_signal` while in CORR_R: OVERRIDE at the next edge, and `assist_right` drops at the same edge.

## Structure
- Shared package `lane_assist_pkg` holds:
  - the 3-bit state encodings above;
  - default parameter constants.
- Sub-module `sensor_debounce` (params `DEBOUNCE`, `CNT_W`; ports `CLK`, `RST`, `raw`, `filt`) is instantiated twice, once per sensor.
- The FSM, counters and output decode live in `lane_assist_ctrl`.

## Test plan
- Reset: hold `RST`=1 for 2 cycles with `enable`=1. Require state=OFF, `assist_disable`=1, other outputs 0. One edge after release, require state=CENTER.
- Debounce: pulse `near_right` for 2 cycles → no change. Hold it for 3 cycles → `assist_right`=1 on the 4th edge. Drop it → back in CENTER after 4 edges.
- Conflict: raise `near_left` and `near_right` together for 6 cycles → state stays CENTER, both assist outputs stay 0.
- Escalation: hold `near_left` for 20+ cycles → `assist_left` for 16 cycles, then `warn`=1 and `assist_disable`=1. Clear the sensor → CENTER after 4 edges.
- Override: assert `turn_signal` during CORR_R → OVERRIDE next edge. Release, re-assert at hold-off cycle 5, release again → CENTER exactly 8 edges after the final release.
- Disable and reset mid-operation: drop `enable` during CORR_L → OFF next edge. Assert `RST` during OVERRIDE → all reset values.
